// File: rtl/mp3_pkg.sv
// Shared SCI definitions for the MP3 decoder control path: write opcode,
// register addresses, the soft-reset mode word and the writer FSM states.
package mp3_pkg;

   localparam logic [7:0]  SCI_OP_WRITE        = 8'h02;
   localparam logic [7:0]  SCI_MODE_ADDR       = 8'h00;
   localparam logic [7:0]  SCI_BASS_ADDR       = 8'h02;
   localparam logic [7:0]  SCI_VOL_ADDR        = 8'h0B;
   // SM_SDINEW | SM_RESET
   localparam logic [15:0] SCI_MODE_SOFT_RESET = 16'h0804;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_DREQ,
      ST_CS_SETUP,
      ST_SHIFT,
      ST_CS_HOLD,
      ST_GAP
   } sci_state_e;

   // Assemble one 32-bit SCI write frame, MSB first on the wire.
   function automatic logic [31:0] sci_frame(input logic [7:0] addr, input logic [15:0] data);
      return {SCI_OP_WRITE, addr, data};
   endfunction

endpackage

// File: rtl/sci_spi_shift.sv
// 32-bit SPI mode-0 shifter with SCLK divider. A start pulse loads the
// frame; each bit spends CLK_DIV cycles with SCLK low then CLK_DIV cycles
// high. MOSI advances on the falling SCLK edge. done_o marks the last
// active cycle so the caller can leave its SHIFT state on the same edge.
module sci_spi_shift #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [31:0] data_i,
   output logic        sclk_o,
   output logic        mosi_o,
   output logic        done_o
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic        active_q;
   logic        high_q;
   logic [7:0]  div_q;
   logic [4:0]  bit_q;
   logic [31:0] sr_q;

   // Divider, SCLK phase and shift register; zeros shift in so MOSI idles low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         high_q   <= 1'b0;
         div_q    <= '0;
         bit_q    <= '0;
         sr_q     <= '0;
      end else if (start_i) begin
         active_q <= 1'b1;
         high_q   <= 1'b0;
         div_q    <= '0;
         bit_q    <= '0;
         sr_q     <= data_i;
      end else if (active_q) begin
         if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (!high_q) begin
               high_q <= 1'b1;
            end else begin
               high_q <= 1'b0;
               sr_q   <= {sr_q[30:0], 1'b0};
               bit_q  <= bit_q + 5'd1;
               if (bit_q == 5'd31) begin
                  active_q <= 1'b0;
               end
            end
         end else begin
            div_q <= div_q + 8'd1;
         end
      end
   end

   assign sclk_o = high_q;
   assign mosi_o = sr_q[31];
   assign done_o = active_q & high_q & (bit_q == 5'd31) & (div_q == DIV_LAST);

endmodule

// File: rtl/mp3_sci_writer.sv
// SCI register writer for the MP3 decoder: tracks pending VOL/BASS (and,
// with SCI_SOFT_RESET_EN defined, a song-change SCI_MODE soft reset),
// arbitrates between them and sequences chip select around the shifter.
module mp3_sci_writer
   import mp3_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] i_vol,
   input  logic [15:0] i_effect,
   input  logic        i_song_change,
   input  logic        i_dreq,
   output logic        o_xcs,
   output logic        o_sclk,
   output logic        o_mosi,
   output logic        o_busy,
   output logic        o_done
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   sci_state_e  state_q;
   logic [7:0]  cnt_q;
   logic        xcs_q, busy_q, done_q;
   logic [31:0] frame_q;
   logic [15:0] shadow_vol_q, shadow_bass_q;
   logic        pend_vol_q, pend_vol_d;
   logic        pend_bass_q, pend_bass_d;
   logic        req_mode;
   logic        launch_mode, launch_vol, launch_bass;
   logic        shift_start, shift_done;

`ifdef SCI_SOFT_RESET_EN
   logic        pend_mode_q, pend_mode_d;
   assign req_mode = pend_mode_q;
`else
   logic        unused_song_change;
   assign req_mode           = 1'b0;
   assign unused_song_change = i_song_change;
`endif

   // Launch arbitration (mode > vol > bass) and pending-flag next state.
   always_comb begin
      launch_mode = (state_q == ST_IDLE) & req_mode;
      launch_vol  = (state_q == ST_IDLE) & ~req_mode & pend_vol_q;
      launch_bass = (state_q == ST_IDLE) & ~req_mode & ~pend_vol_q & pend_bass_q;
      pend_vol_d  = launch_vol  ? 1'b0 : (pend_vol_q  | (i_vol    != shadow_vol_q));
      pend_bass_d = launch_bass ? 1'b0 : (pend_bass_q | (i_effect != shadow_bass_q));
`ifdef SCI_SOFT_RESET_EN
      pend_mode_d = i_song_change | (pend_mode_q & ~launch_mode);
`endif
   end

   assign shift_start = (state_q == ST_CS_SETUP) && (cnt_q == DIV_LAST);

   // Transaction FSM with registered chip select, busy and done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         xcs_q         <= 1'b1;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         frame_q       <= '0;
         shadow_vol_q  <= '0;
         shadow_bass_q <= '0;
         pend_vol_q    <= 1'b1;
         pend_bass_q   <= 1'b1;
`ifdef SCI_SOFT_RESET_EN
         pend_mode_q   <= 1'b0;
`endif
      end else begin
         pend_vol_q  <= pend_vol_d;
         pend_bass_q <= pend_bass_d;
`ifdef SCI_SOFT_RESET_EN
         pend_mode_q <= pend_mode_d;
`endif
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (launch_mode || launch_vol || launch_bass) begin
                  busy_q  <= 1'b1;
                  state_q <= ST_WAIT_DREQ;
               end
               if (launch_mode) begin
                  frame_q <= sci_frame(SCI_MODE_ADDR, SCI_MODE_SOFT_RESET);
               end else if (launch_vol) begin
                  frame_q      <= sci_frame(SCI_VOL_ADDR, i_vol);
                  shadow_vol_q <= i_vol;
               end else if (launch_bass) begin
                  frame_q       <= sci_frame(SCI_BASS_ADDR, i_effect);
                  shadow_bass_q <= i_effect;
               end
            end
            ST_WAIT_DREQ: begin
               if (i_dreq) begin
                  xcs_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= ST_CS_SETUP;
               end
            end
            ST_CS_SETUP: begin
               if (cnt_q == DIV_LAST) begin
                  cnt_q   <= '0;
                  state_q <= ST_SHIFT;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            ST_SHIFT: begin
               if (shift_done) begin
                  cnt_q   <= '0;
                  state_q <= ST_CS_HOLD;
               end
            end
            ST_CS_HOLD: begin
               if (cnt_q == DIV_LAST) begin
                  xcs_q   <= 1'b1;
                  done_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= ST_GAP;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            ST_GAP: begin
               if (cnt_q == DIV_LAST) begin
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   sci_spi_shift #(.CLK_DIV(CLK_DIV)) u_shift (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (shift_start),
      .data_i  (frame_q),
      .sclk_o  (o_sclk),
      .mosi_o  (o_mosi),
      .done_o  (shift_done)
   );

   assign o_xcs  = xcs_q;
   assign o_busy = busy_q;
   assign o_done = done_q;

endmodule

// File: tb/tb_mp3_sci_writer.sv
// Scoreboard bench for mp3_sci_writer: stimulus pushes expected SCI frames,
// a monitor decodes frames off the SPI pins and checks them plus timing.
module tb_mp3_sci_writer;

   localparam int CLK_DIV = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] i_vol, i_effect;
   logic        i_song_change, i_dreq;
   logic        o_xcs, o_sclk, o_mosi, o_busy, o_done;

   int compared   = 0;
   int mismatched = 0;
   logic [31:0] expq[$];
   int mon_bits = 0, mon_low = 0, mon_hi = 0, done_cnt = 0;
   logic mon_seen = 1'b0;

   always #5 clk = ~clk;

   mp3_sci_writer #(.CLK_DIV(CLK_DIV)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_vol         (i_vol),
      .i_effect      (i_effect),
      .i_song_change (i_song_change),
      .i_dreq        (i_dreq),
      .o_xcs         (o_xcs),
      .o_sclk        (o_sclk),
      .o_mosi        (o_mosi),
      .o_busy        (o_busy),
      .o_done        (o_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: decode frames on SCLK rising edges while XCS is low.
   logic        pxcs = 1'b1, psclk = 1'b0;
   logic [31:0] fr = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         pxcs = 1'b1; psclk = 1'b0; mon_bits = 0; mon_low = 0; mon_hi = 0; mon_seen = 1'b0;
      end else begin
         if (!o_xcs && pxcs) begin
            if (mon_seen) check("xcs_high_gap", 32'(mon_hi >= CLK_DIV), 32'd1);
            mon_bits = 0; mon_low = 0; fr = '0;
         end
         if (!o_xcs) begin
            mon_low++;
            if (o_sclk && !psclk) begin
               fr = {fr[30:0], o_mosi};
               mon_bits++;
            end
         end else begin
            mon_hi++;
         end
         if (o_xcs && !pxcs) begin
            check("done_at_xcs_rise", 32'(o_done), 32'd1);
            check("frame_bits", mon_bits, 32);
            check("xcs_low_time", mon_low, 66 * CLK_DIV);
            if (expq.size() == 0) begin
               compared++; mismatched++;
               $display("FAIL unexpected_frame: got %h expected none", fr);
            end else begin
               check("frame", fr, expq.pop_front());
            end
            mon_seen = 1'b1; mon_hi = 0;
         end else if (o_done) begin
            compared++; mismatched++;
            $display("FAIL stray_done: got 1 expected 0");
         end
         if (o_done) done_cnt++;
         pxcs = o_xcs; psclk = o_sclk;
      end
   end

   task automatic wait_idle(input string name);
      int n = 0;
      while ((expq.size() != 0 || o_busy) && n < 20000) begin
         @(negedge clk); n++;
      end
      check({name, "_timeout"}, 32'(n < 20000), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_bits(input int k);
      int n = 0;
      while (mon_bits != k && n < 5000) begin
         @(negedge clk); n++;
      end
      check("wait_bits_timeout", 32'(n < 5000), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int lows;
      rst_n = 1'b0; i_dreq = 1'b1; i_vol = 16'h0E0E; i_effect = 16'h0000; i_song_change = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_xcs",  32'(o_xcs),  32'd1);
      check("rst_sclk", 32'(o_sclk), 32'd0);
      check("rst_mosi", 32'(o_mosi), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);

      // Post-reset initialisation: VOL then BASS.
      expq.push_back(32'h020B0E0E);
      expq.push_back(32'h02020000);
      d0 = done_cnt;
      rst_n = 1'b1;
      wait_idle("init");
      check("init_done_pulses", done_cnt - d0, 2);

      // Held off by DREQ low, then exactly one frame.
      i_dreq = 1'b0; i_vol = 16'h1C1C;
      expq.push_back(32'h020B1C1C);
      lows = 0;
      repeat (200) begin @(negedge clk); if (!o_xcs) lows++; end
      check("dreq_low_xcs_idle", lows, 0);
      check("dreq_low_busy", 32'(o_busy), 32'd1);
      i_dreq = 1'b1;
      wait_idle("dreq");

      // Change mid-SHIFT: current frame keeps 1C1C, follow-up carries 2A2A.
      i_vol = 16'h0505;
      expq.push_back(32'h020B0505);
      wait_idle("pre_mid");
      i_vol = 16'h1C1C;
      expq.push_back(32'h020B1C1C);
      expq.push_back(32'h020B2A2A);
      wait_bits(8);
      i_vol = 16'h2A2A;
      wait_idle("mid_shift");

      // Simultaneous VOL and BASS change: back-to-back frames, VOL first.
      i_vol = 16'h1111; i_effect = 16'h0022;
      expq.push_back(32'h020B1111);
      expq.push_back(32'h02020022);
      wait_idle("b2b");

`ifdef SCI_SOFT_RESET_EN
      // Song change with VOL change: MODE first, then VOL.
      i_song_change = 1'b1; i_vol = 16'h4545;
      expq.push_back(32'h02000804);
      expq.push_back(32'h020B4545);
      @(negedge clk); i_song_change = 1'b0;
      wait_idle("mode_vol");
      // Two song-change pulses while a VOL frame waits on DREQ merge into one.
      i_dreq = 1'b0; i_vol = 16'h5656;
      expq.push_back(32'h020B5656);
      expq.push_back(32'h02000804);
      repeat (5) @(negedge clk);
      i_song_change = 1'b1; @(negedge clk); i_song_change = 1'b0;
      repeat (5) @(negedge clk);
      i_song_change = 1'b1; @(negedge clk); i_song_change = 1'b0;
      repeat (5) @(negedge clk);
      i_dreq = 1'b1;
      wait_idle("mode_merge");
`else
      // Song change has no effect in this build.
      i_song_change = 1'b1; @(negedge clk); i_song_change = 1'b0;
      lows = 0;
      repeat (100) begin @(negedge clk); if (!o_xcs) lows++; end
      check("song_change_ignored", lows, 0);
      check("song_change_busy", 32'(o_busy), 32'd0);
`endif

      // Reset during bit 10 abandons the frame and repeats initialisation.
      i_vol = 16'h7777;
      expq.push_back(32'h020B7777);
      wait_bits(10);
      #2 rst_n = 1'b0;
      expq.delete();
      #1;
      check("midrst_xcs",  32'(o_xcs),  32'd1);
      check("midrst_sclk", 32'(o_sclk), 32'd0);
      i_vol = 16'h0E0E; i_effect = 16'h0000;
      repeat (3) @(negedge clk);
      check("midrst_done", 32'(o_done), 32'd0);
      expq.push_back(32'h020B0E0E);
      expq.push_back(32'h02020000);
      d0 = done_cnt;
      rst_n = 1'b1;
      wait_idle("reinit");
      check("reinit_done_pulses", done_cnt - d0, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
